// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
//   Shared definitions for the execute-stage iterative datapaths (divider and
//   multiplier): the 2-bit FSM state encoding, the default operand width and
//   a helper to size iteration counters.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

    // Default operand/result width for the execute-stage datapaths.
    localparam int DIV_WIDTH = 32;

    // FSM encoding shared by the iterative units.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    // Width of a counter that must reach w-1 (at least one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
//   Request/result bundle of the sequential divider.
//   Handshake: the requester raises start with signed_op/dividend/divisor
//   valid; the divider accepts it only while idle (busy=0). busy stays high
//   from acceptance through the done cycle; done pulses for one cycle when
//   quotient/remainder/div_by_zero are valid. Those results then hold until
//   the next operation completes. A start seen while busy is dropped, never
//   queued.
//   master : requester (drives start/operands, reads results)
//   slave  : divider   (reads start/operands, drives results)
// -----------------------------------------------------------------------------
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration.
//   rem_in  : current partial remainder (WIDTH+1 bits)
//   q_in    : next dividend bit shifted into the partial remainder
//   divisor : divisor magnitude
//   rem_out : next partial remainder
//   q_out   : resulting quotient bit (1 when the trial subtract fits)
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_out
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in, q_in};
        diff    = shifted - {2'b00, divisor};
        // Top bit of diff is the borrow: set means divisor did not fit,
        // so the shifted value is kept (restored).
        q_out   = ~diff[WIDTH+1];
        rem_out = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
    end
endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative restoring divider, signed or unsigned, one quotient bit per
//   clock. Fixed latency: done pulses WIDTH+1 clock edges after the edge that
//   accepted start. Division by zero yields quotient all ones, remainder equal
//   to the dividend and div_by_zero set. Signed division truncates toward zero
//   (remainder takes the sign of the dividend).
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : request/result bundle (slave side)
//   dbg_state : current FSM state
// -----------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_divider_if.slave        bus,
    output div_state_t          dbg_state
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_reg;      // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] d_reg;      // divisor magnitude
    logic [WIDTH:0]   rem_reg;    // partial remainder with borrow headroom
    logic [WIDTH-1:0] dvd_orig;   // untouched dividend for the divide-by-zero result
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;

    // Operand magnitudes taken straight from the request at acceptance.
    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dsr_abs;

    always_comb begin
        dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
        dsr_neg = bus.signed_op & bus.divisor[WIDTH-1];
        dvd_abs = dvd_neg ? -bus.dividend : bus.dividend;
        dsr_abs = dsr_neg ? -bus.divisor  : bus.divisor;
    end

    logic [WIDTH:0] step_rem;
    logic           step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .q_in    (q_reg[WIDTH-1]),
        .divisor (d_reg),
        .rem_out (step_rem),
        .q_out   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            rem_reg     <= '0;
            dvd_orig    <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dz_r        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        q_reg    <= dvd_abs;
                        d_reg    <= dsr_abs;
                        rem_reg  <= '0;
                        cnt      <= '0;
                        dvd_orig <= bus.dividend;
                        neg_q    <= dvd_neg ^ dsr_neg;
                        neg_r    <= dvd_neg;
                        dz       <= (bus.divisor == '0);
                        busy_r   <= 1'b1;
                        state    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    rem_reg <= step_rem;
                    q_reg   <= {q_reg[WIDTH-2:0], step_q};
                    // Counter parks at its last value; it is reloaded on the
                    // next acceptance.
                    if (cnt == CNT_LAST) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_FIX: begin
                    if (dz) begin
                        quotient_r  <= '1;
                        remainder_r <= dvd_orig;
                        dz_r        <= 1'b1;
                    end else begin
                        // Most-negative / -1 needs no special case: the
                        // magnitude quotient negates back onto itself.
                        quotient_r  <= neg_q ? -q_reg : q_reg;
                        remainder_r <= neg_r ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
                        dz_r        <= 1'b0;
                    end
                    done_r <= 1'b1;
                    state  <= ST_DONE;
                end

                ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dz_r;
    assign dbg_state       = state;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
    import seq_divider_pkg::*;

    logic       clk;
    logic       rst_n;
    div_state_t dbg_state;
    int         total;
    int         bad;
    int         lat;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one rising edge; returns 1ns after it.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) break;
        end
    endtask

    task automatic run_check(input string tag, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eq,
                             input logic [31:0] er, input logic edz);
        start_op(s, a, b);
        check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
        wait_done(lat);
        check({tag, "_lat"}, lat, 32'd33);
        check({tag, "_q"}, bus.quotient, eq);
        check({tag, "_r"}, bus.remainder, er);
        check({tag, "_dz"}, {31'b0, bus.div_by_zero}, {31'b0, edz});
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_hold_q"}, bus.quotient, eq);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", bus.quotient, 32'd0);
        check("rst_r", bus.remainder, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_dz", {31'b0, bus.div_by_zero}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_check("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_check("s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_check("s100_-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 1'b0);
        run_check("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_check("u_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_check("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_check("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_check("u_1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

        // reset in the middle of an operation
        start_op(1'b0, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_q", bus.quotient, 32'd0);
        check("mid_rst_r", bus.remainder, 32'd0);
        check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mid_rst_done_lo", {31'b0, bus.done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_done", {31'b0, bus.done}, 32'd0);
        end
        run_check("post_rst_u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // start while busy is dropped
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        check("busy_start_lat", lat + 10, 32'd33);
        check("busy_start_q", bus.quotient, 32'd14);
        check("busy_start_r", bus.remainder, 32'd2);

        // start in the done cycle is dropped, the next cycle accepted
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd50;
        bus.divisor   = 32'd5;
        @(posedge clk);
        #1;
        check("done_start_busy", {31'b0, bus.busy}, 32'd0);
        check("done_start_state", {30'b0, dbg_state}, 32'd0);
        check("done_start_q", bus.quotient, 32'd14);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_busy", {31'b0, bus.busy}, 32'd1);
        wait_done(lat);
        check("b2b_lat", lat, 32'd33);
        check("b2b_q", bus.quotient, 32'd10);
        check("b2b_r", bus.remainder, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have port signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port dividend  input  WIDTH  numerator, sampled with start.
REQ-007 SHALL have port divisor  input  WIDTH  denominator, sampled with start.
REQ-008 SHALL have port quotient  output  WIDTH  registered result.
REQ-009 SHALL have port remainder  output  WIDTH  registered result.
REQ-010 SHALL have port busy  output  1  high from acceptance until done cycle inclusive.
REQ-011 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-012 SHALL have port div_by_zero  output  1  registered flag, valid with done, held thereafter.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> FIX -> DONE -> IDLE.
REQ-014 IDLE: start=1 at edge k latches operands, absolute values (signed_op=1), sign flags, clears partial remainder and iteration counter, enters RUN.
REQ-015 RUN: one restoring shift-subtract step per cycle for exactly WIDTH cycles (edges k+1..k+WIDTH); counter saturates at WIDTH-1, then transitions to FIX.
REQ-016 FIX: negate quotient when dividend and divisor signs differ; negate remainder when dividend negative; update output registers; enter DONE at edge k+WIDTH+1.
REQ-017 DONE: done=1 for exactly one cycle, then IDLE; fixed latency WIDTH+1 edges from acceptance to done (33 for WIDTH=32).
REQ-018 busy SHALL equal (state != IDLE); start while busy SHALL be ignored, not queued.
REQ-019 start asserted in the DONE cycle SHALL be ignored; start in the IDLE cycle after DONE SHALL be accepted (back-to-back throughput WIDTH+3 cycles).
REQ-020 quotient, remainder, div_by_zero SHALL hold their values until the next FIX update.
REQ-021 Divisor zero: quotient = all ones, remainder = original dividend, div_by_zero=1, same latency as normal operation.
REQ-022 Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, div_by_zero=0.
REQ-023 Remainder SHALL satisfy dividend = quotient*divisor + remainder, |remainder| < |divisor|, remainder sign = dividend sign (truncating division).
REQ-024 Internal partial remainder SHALL be WIDTH+1 bits to hold trial-subtract borrow.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-026 Reset mid-operation SHALL abandon the division without producing done; first start after release accepted normally.
REQ-027 Reset deassertion SHALL be assumed synchronized upstream; no internal synchronizer.

Structure
REQ-028 Shared package SHALL hold FSM state encoding (2-bit: IDLE=0, RUN=1, FIX=2, DONE=3) and the default WIDTH constant, shared with the multiplier datapath of the execute stage.
REQ-029 One sub-module div_step SHALL be instantiated: combinational single restoring iteration (partial remainder, quotient bit in; next partial remainder, quotient bit out).
REQ-030 No multi-cycle combinational path; sign correction SHALL occur only in FIX.

Verification
REQ-031 Unsigned 100/7 -> quotient 14, remainder 2, div_by_zero 0, done exactly 33 cycles after start.
REQ-032 Signed -100/7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; signed 100/-7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF/2 -> quotient 0x7FFFFFFF, remainder 1.
REQ-034 Divide 5/0 (both modes) -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1.
REQ-035 start pulsed again at cycle 10 of an operation -> ignored, first result unchanged; start in DONE cycle ignored; start next cycle accepted.
REQ-036 rst_n low at cycle 15 of an operation -> outputs zero immediately, no done pulse; new 100/7 after release completes correctly.
